// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch sweep driver: FSM states and target LED codes.
package glitch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StDelay,
    StGlitch,
    StObserve,
    StRelease,
    StDone
  } state_e;

  localparam logic [2:0] LED_IDLE  = 3'b111;
  localparam logic [2:0] LED_RED   = 3'b110;
  localparam logic [2:0] LED_OFF   = 3'b000;
  localparam logic [2:0] LED_BLUE  = 3'b011;
  localparam logic [2:0] LED_GREEN = 3'b101;

  // Blue and green both mean the target accepted the password.
  function automatic logic led_is_success(input logic [2:0] led);
    return (led == LED_BLUE) || (led == LED_GREEN);
  endfunction

endpackage

// File: rtl/glitch_sweep_driver_if.sv
// Control/status and target-facing signals of the glitch sweep driver.
interface glitch_sweep_driver_if #(
  parameter int unsigned DELAY_W = 24
);
  logic               start;
  logic [2:0]         led_in;
  logic [7:0]         password_out;
  logic               enter_out;
  logic               glitch_out;
  logic               busy;
  logic               found;
  logic [DELAY_W-1:0] found_delay;
  logic [15:0]        attempt_count;

  modport master (
    input  start,
    input  led_in,
    output password_out,
    output enter_out,
    output glitch_out,
    output busy,
    output found,
    output found_delay,
    output attempt_count
  );

  modport slave (
    output start,
    output led_in,
    input  password_out,
    input  enter_out,
    input  glitch_out,
    input  busy,
    input  found,
    input  found_delay,
    input  attempt_count
  );
endinterface

// File: rtl/led_outcome_classifier.sv
// Classifies the target LED during an observe window into single-cycle success/fail pulses.
module led_outcome_classifier
  import glitch_pkg::*;
#(
  parameter int unsigned FAIL_HOLD   = 4,
  parameter int unsigned OBSERVE_MAX = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       active,
  input  logic [2:0] led,
  output logic       success,
  output logic       fail
);

  logic [31:0] off_q;
  logic [31:0] obs_q;
  logic        is_off;
  logic        off_expired;
  logic        obs_expired;

  always_comb begin
    is_off      = (led == LED_OFF);
    off_expired = is_off && (off_q == FAIL_HOLD - 1);
    obs_expired = (obs_q == OBSERVE_MAX - 1);
    success     = active && led_is_success(led);
    // Success wins when it coincides with either fail condition.
    fail        = active && !success && (off_expired || obs_expired);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q <= '0;
      obs_q <= '0;
    end else if (clear) begin
      off_q <= '0;
      obs_q <= '0;
    end else if (active) begin
      // Any non-OFF cycle breaks the run, so single-cycle bit-check ticks never count.
      off_q <= is_off ? off_q + 32'd1 : '0;
      obs_q <= obs_q + 32'd1;
    end
  end

endmodule

// File: rtl/glitch_sweep_driver.sv
// Sweeps the enter-to-glitch delay against a password-checking target until it reports success.
// Optional ATTACK_STATS_EN macro enables the found_delay and attempt_count outputs.
module glitch_sweep_driver
  import glitch_pkg::*;
#(
  parameter logic [7:0]  GUESS        = 8'h00,
  parameter int unsigned DELAY_W      = 24,
  parameter int unsigned DELAY_MIN    = 0,
  parameter int unsigned DELAY_STEP   = 1024,
  parameter int unsigned DELAY_MAX    = 16_000_000,
  parameter int unsigned GLITCH_WIDTH = 4,
  parameter int unsigned FAIL_HOLD    = 4,
  parameter int unsigned OBSERVE_MAX  = 200_000_000,
  parameter int unsigned SETTLE       = 16
) (
  input logic                   clk,
  input logic                   rst,
  glitch_sweep_driver_if.master bus
);

  localparam logic [DELAY_W:0] StepExt = (DELAY_W + 1)'(DELAY_STEP);
  localparam logic [DELAY_W:0] MaxExt  = (DELAY_W + 1)'(DELAY_MAX);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [DELAY_W:0]   delay_next;
  logic               start_accept;
  logic               success_take;
  logic               obs_clear;
  logic               obs_success;
  logic               obs_fail;

  led_outcome_classifier #(
    .FAIL_HOLD   (FAIL_HOLD),
    .OBSERVE_MAX (OBSERVE_MAX)
  ) u_classifier (
    .clk     (clk),
    .rst     (rst),
    .clear   (obs_clear),
    .active  (state_q == StObserve),
    .led     (bus.led_in),
    .success (obs_success),
    .fail    (obs_fail)
  );

  // One extra bit so delay + step can never wrap past DELAY_MAX.
  assign delay_next = {1'b0, delay_q} + StepExt;

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    found_d      = found_q;
    cnt_d        = cnt_q + 32'd1;
    start_accept = 1'b0;
    success_take = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        cnt_d = '0;
        if (bus.start) begin
          start_accept = 1'b1;
          state_d      = StPress;
          delay_d      = DELAY_W'(DELAY_MIN);
          found_d      = 1'b0;
        end
      end
      StPress: begin
        state_d = (delay_q == '0) ? StGlitch : StDelay;
      end
      StDelay: begin
        if (cnt_q + 32'd1 == 32'(delay_q)) state_d = StGlitch;
      end
      StGlitch: begin
        if (cnt_q == GLITCH_WIDTH - 1) state_d = StObserve;
      end
      StObserve: begin
        if (obs_success) begin
          success_take = 1'b1;
          found_d      = 1'b1;
          state_d      = StDone;
        end else if (obs_fail) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (bus.led_in != LED_IDLE) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE - 1) begin
          if (delay_next > MaxExt) begin
            state_d = StDone;
          end else begin
            delay_d = delay_next[DELAY_W-1:0];
            state_d = StPress;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Every state that times itself starts counting from zero on entry.
    if (state_d != state_q) cnt_d = '0;
  end

  assign obs_clear = (state_d == StObserve) && (state_q != StObserve);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      delay_q <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign bus.password_out = GUESS;
  assign bus.enter_out    = (state_q == StPress) || (state_q == StDelay) ||
                            (state_q == StGlitch) || (state_q == StObserve);
  assign bus.glitch_out   = (state_q == StGlitch);
  assign bus.busy         = (state_q != StIdle) && (state_q != StDone);
  assign bus.found        = found_q;

`ifdef ATTACK_STATS_EN
  logic [DELAY_W-1:0] found_delay_q;
  logic [15:0]        attempt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_delay_q <= '0;
      attempt_q     <= '0;
    end else begin
      if (start_accept) begin
        attempt_q <= '0;
      end else if ((state_q == StPress) && (attempt_q != 16'hFFFF)) begin
        attempt_q <= attempt_q + 16'd1;
      end
      if (success_take) found_delay_q <= delay_q;
    end
  end

  assign bus.found_delay   = found_delay_q;
  assign bus.attempt_count = attempt_q;
`else
  logic stats_unused;
  assign stats_unused      = start_accept ^ success_take;
  assign bus.found_delay   = '0;
  assign bus.attempt_count = '0;
`endif

endmodule
